// File: rtl/window3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood window via two line buffers.
// Define WINDOW_COORD_EN to add centerX/centerY outputs.
module window3x3_gen #(
  parameter int inputWidth = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [inputWidth-1:0]     pixelIn,
  input  logic                      pixelInValid,
  input  logic                      sof,
`ifdef WINDOW_COORD_EN
  output logic [X_BITS-1:0]         centerX,
  output logic [Y_BITS-1:0]         centerY,
`endif
  output logic [inputWidth*9-1:0]   windowOut,
  output logic                      windowValid
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [X_BITS-1:0]     col_q, col_d, cur_col;
  logic [Y_BITS-1:0]     row_q, row_d, cur_row;
  logic [AW-1:0]         addr;
  logic                  valid_q, valid_d;
  logic [inputWidth-1:0] win_q [9];
  logic [inputWidth-1:0] lb1 [IMG_W];
  logic [inputWidth-1:0] lb2 [IMG_W];
  logic [inputWidth-1:0] top, mid;

  // sof forces the accepted pixel to (0,0) whatever the counters say
  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    col_d   = cur_col + X_BITS'(1);
    row_d   = cur_row;
    if (cur_col == X_BITS'(IMG_W - 1)) begin
      col_d = '0;
      if (cur_row == Y_BITS'(IMG_H - 1)) begin
        row_d = '0;
      end else begin
        row_d = cur_row + Y_BITS'(1);
      end
    end
    valid_d = pixelInValid
            && (cur_col >= X_BITS'(2))
            && (cur_row >= Y_BITS'(2));
  end

  assign addr = cur_col[AW-1:0];
  assign top  = lb2[addr];
  assign mid  = lb1[addr];

  // Line buffers are plain storage, never reset
  always_ff @(posedge clk) begin
    if (pixelInValid) begin
      lb2[addr] <= lb1[addr];
      lb1[addr] <= pixelIn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
`ifdef WINDOW_COORD_EN
      centerX <= '0;
      centerY <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      if (pixelInValid) begin
        col_q    <= col_d;
        row_q    <= row_d;
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= top;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= mid;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= pixelIn;
`ifdef WINDOW_COORD_EN
        centerX  <= cur_col - X_BITS'(1);
        centerY  <= cur_row - Y_BITS'(1);
`endif
      end
    end
  end

  always_comb begin
    windowOut = '0;
    for (int i = 0; i < 9; i++) begin
      windowOut[i*inputWidth +: inputWidth] = win_q[i];
    end
  end

  assign windowValid = valid_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Self-checking bench for window3x3_gen on a 5x4 image.
// Frame-array reference model plus fixed expected-window table.
module tb_window3x3_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pixelIn;
  logic          pixelInValid;
  logic          sof;
  logic [PW*9-1:0] windowOut;
  logic          windowValid;
`ifdef WINDOW_COORD_EN
  logic [2:0]    centerX;
  logic [2:0]    centerY;
`endif

  always #5 clk = ~clk;

  window3x3_gen #(
    .inputWidth(PW), .IMG_W(W), .IMG_H(H),
    .X_BITS(3), .Y_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pixelIn(pixelIn),
    .pixelInValid(pixelInValid),
    .sof(sof),
`ifdef WINDOW_COORD_EN
    .centerX(centerX),
    .centerY(centerY),
`endif
    .windowOut(windowOut),
    .windowValid(windowValid)
  );

  typedef struct {
    int       cx;
    int       cy;
    logic [7:0] w0, w2, w4, w6, w8;
  } vec_t;

  typedef struct {
    logic [PW*9-1:0] w;
    int cx;
    int cy;
  } cap_t;

  int   tests = 0;
  int   fails = 0;
  int   mcol, mrow;
  logic [7:0] frame [H][W];
  vec_t tbl [6];
  cap_t cap [$];

  task automatic chk(input string n,
                     input logic [PW*9-1:0] a,
                     input logic [PW*9-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [7:0] el(input logic [PW*9-1:0] w,
                                    input int i);
    return w[i*PW +: PW];
  endfunction

  // One clock: drive, let the edge happen, update model, check
  task automatic step(input bit v, input bit s, input logic [7:0] p);
    logic            ev;
    logic [PW*9-1:0] ew;
    int pc, pr;
    pixelInValid = v;
    sof          = s;
    pixelIn      = p;
    @(posedge clk);
    ev = 1'b0;
    ew = '0;
    pc = 0;
    pr = 0;
    if (v) begin
      pc = s ? 0 : mcol;
      pr = s ? 0 : mrow;
      frame[pr][pc] = p;
      if (pc >= 2 && pr >= 2) begin
        ev = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ew[(r*3+c)*PW +: PW] = frame[pr-2+r][pc-2+c];
      end
      mcol = pc + 1;
      mrow = pr;
      if (mcol == W) begin
        mcol = 0;
        mrow = (pr + 1 == H) ? 0 : pr + 1;
      end
    end
    #1;
    chk("windowValid", 72'(windowValid), 72'(ev));
    if (ev) begin
      chk("windowOut", windowOut, ew);
`ifdef WINDOW_COORD_EN
      chk("centerX", 72'(centerX), 72'(pc - 1));
      chk("centerY", 72'(centerY), 72'(pr - 1));
      cap.push_back('{windowOut, int'(centerX), int'(centerY)});
`else
      cap.push_back('{windowOut, pc - 1, pr - 1});
`endif
    end
    pixelInValid = 1'b0;
    sof          = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] off, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, (r == 0 && c == 0), off + 8'(r*16 + c));
        if (gaps) step(1'b0, 1'b0, 8'($urandom));
      end
  endtask

  task automatic check_table(input string tag);
    chk({tag, "_count"}, 72'(cap.size()), 72'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < cap.size()) begin
        chk({tag, "_w0"}, 72'(el(cap[i].w, 0)), 72'(tbl[i].w0));
        chk({tag, "_w2"}, 72'(el(cap[i].w, 2)), 72'(tbl[i].w2));
        chk({tag, "_w4"}, 72'(el(cap[i].w, 4)), 72'(tbl[i].w4));
        chk({tag, "_w6"}, 72'(el(cap[i].w, 6)), 72'(tbl[i].w6));
        chk({tag, "_w8"}, 72'(el(cap[i].w, 8)), 72'(tbl[i].w8));
`ifdef WINDOW_COORD_EN
        chk({tag, "_cx"}, 72'(cap[i].cx), 72'(tbl[i].cx));
        chk({tag, "_cy"}, 72'(cap[i].cy), 72'(tbl[i].cy));
`endif
      end
    end
  endtask

  initial begin
    tbl[0] = '{1, 1, 8'h00, 8'h02, 8'h11, 8'h20, 8'h22};
    tbl[1] = '{2, 1, 8'h01, 8'h03, 8'h12, 8'h21, 8'h23};
    tbl[2] = '{3, 1, 8'h02, 8'h04, 8'h13, 8'h22, 8'h24};
    tbl[3] = '{1, 2, 8'h10, 8'h12, 8'h21, 8'h30, 8'h32};
    tbl[4] = '{2, 2, 8'h11, 8'h13, 8'h22, 8'h31, 8'h33};
    tbl[5] = '{3, 2, 8'h12, 8'h14, 8'h23, 8'h32, 8'h34};

    rst          = 1'b1;
    pixelInValid = 1'b0;
    sof          = 1'b0;
    pixelIn      = '0;
    mcol         = 0;
    mrow         = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 72'(windowValid), 72'd0);
    chk("reset_out", windowOut, '0);
    rst = 1'b0;

    send_frame(8'h00, 1'b0);
    check_table("frame");
    cap.delete();

    send_frame(8'h00, 1'b1);
    check_table("gaps");
    cap.delete();

    send_frame(8'h80, 1'b0);
    chk("b2b_count", 72'(cap.size()), 72'd6);
    if (cap.size() > 0) begin
      chk("b2b_w0", 72'(el(cap[0].w, 0)), 72'h80);
      chk("b2b_w8", 72'(el(cap[0].w, 8)), 72'hA2);
    end
    cap.delete();

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if (r < 2 || c < 3) step(1'b1, (r == 0 && c == 0), 8'h40 + 8'(r*16 + c));
    cap.delete();
    send_frame(8'h00, 1'b0);
    check_table("midsof");
    if (cap.size() > 0)
      chk("midsof_first_w8", 72'(el(cap[0].w, 8)), 72'h22);
    cap.delete();

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        step(1'b1, (r == 0 && c == 0), 8'hC0 + 8'(r*16 + c));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 72'(windowValid), 72'd0);
    chk("rst_mid_out", windowOut, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    mcol = 0;
    mrow = 0;
    cap.delete();
    send_frame(8'h00, 1'b0);
    check_table("postrst");
    cap.delete();

    repeat (1500)
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 80) == 0,
           8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/window3x3_gen.md
Name: window3x3_gen

Overview:
- Raster-scan pixel stream in; 3x3 neighbourhood window out, packed for the downstream 3x3 LBP/threshold stage.
- Two line buffers plus a 3x3 register array; one window is produced per accepted pixel once the window is fully inside the image.
- No backpressure; upstream drives at most one pixel per clock.

Parameters:
- inputWidth, 8, bits per pixel
- IMG_W, 640, pixels per line (>=3)
- IMG_H, 480, lines per frame (>=3)
- X_BITS, 10, column counter width (2^X_BITS >= IMG_W)
- Y_BITS, 10, row counter width (2^Y_BITS >= IMG_H)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- pixelIn  input  inputWidth  raster pixel, row-major, top-left first
- pixelInValid  input  1  pixelIn valid this cycle
- sof  input  1  start of frame; qualified by pixelInValid; marks pixel (0,0)
- windowOut  output  inputWidth*9  packed window; element i at bits [i*inputWidth+inputWidth-1 : i*inputWidth]
- windowValid  output  1  one-cycle strobe, windowOut valid

Behaviour:
- Window indexing is row-major: 0,1,2 top (oldest line); 3,4,5 middle (4 = centre); 6,7,8 bottom (current line). 8 = newest pixel.
- Column 0,3,6 is the oldest column.
- Accepted pixel = pixelInValid high at a clk edge. Cycles with pixelInValid low change nothing (counters, buffers, window regs hold); windowValid = 0.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the accepted pixel.
  - col wraps to 0 with row+1.
  - At (IMG_W-1, IMG_H-1) both wrap to 0.
- sof with pixelInValid: the pixel is (0,0) regardless of counter state; next pixel is (1,0). sof without pixelInValid is ignored.
- Line buffers:
  - LB1 holds the previous line; LB2 holds the line before that. Each is IMG_W deep, addressed by col.
  - On accept: read LB2[col] and LB1[col] as the top and middle taps; write LB2[col] <= LB1[col] and LB1[col] <= pixelIn.
  - Read-before-write in the same cycle.
- Window regs: on accept, each row shifts one column toward the oldest column; new column = {LB2[col], LB1[col], pixelIn}.
- windowValid <= 1 on the cycle after an accepted pixel with col >= 2 and row >= 2; else 0.
- Latency: 1 clk from the accepted pixel to the window whose element 8 is that pixel. Window centre is (col-1, row-1).
- Exactly (IMG_W-2)*(IMG_H-2) windows per frame. No border windows; a window never straddles two lines.
- Stale line-buffer or window-register data after a line wrap or sof is never output, because validity is gated by col/row.
- Reset (async assert, any time including mid-frame): windowValid = 0, windowOut = 0, col = 0, row = 0, all window regs = 0.
  - Line-buffer memory is not cleared.
  - First pixel after reset is (0,0).
  - Deassertion is synchronous to clk (external reset synchroniser).
- sof mid-frame: counters restart; no valid window until row >= 2 of the new frame.

Optional Feature:
- Macro WINDOW_COORD_EN.
- Defined: adds outputs centerX (X_BITS) and centerY (Y_BITS), registered with windowOut, equal to (col-1, row-1) of the centre pixel; reset to 0.
- Not defined: ports absent; all other behaviour identical.

Test Plan:
- IMG_W=5, IMG_H=4, continuous valid, pixel = row*16+col, sof on first pixel -> first windowValid one cycle after pixel 0x22 is accepted; win0=0x00, win4=0x11, win8=0x22, win2=0x02, win6=0x20.
- Same full frame -> exactly 6 windowValid strobes, centres (1..3, 1..2) in raster order; none while row 0/1 or col 0/1 is being accepted.
- Same frame with pixelInValid low every other cycle -> identical window sequence and contents; windowValid never high on a gap+1 cycle.
- Two back-to-back frames (second offset by +0x80) -> second frame's first window has win0=0x80, win8=0xA2; no window emitted across the frame boundary.
- sof asserted at pixel (3,2) mid-frame -> no windowValid until new row 2, col 2; that window has win8 = the new frame's 0x22.
- rst pulsed mid-frame, then a new frame -> outputs 0 immediately on assert; after release, 6 correct windows.
- With WINDOW_COORD_EN: centerX/centerY match each window's centre.
